// File: rtl/nco_lut_sequencer_if.sv
// nco_lut_sequencer_if
// Connects the NCO sequencer to the quarter-wave sine table and to the downstream mixer.
//   lut_addr  : table address, driven by the sequencer
//   lut_data  : registered table output, valid one cycle after lut_addr
//   out_sin   : signed 15-bit sine sample
//   out_cos   : signed 15-bit cosine sample
//   out_valid : I/Q pair valid
//   out_ready : downstream accepts the pair
// master = sequencer side, slave = table/mixer side.
interface nco_lut_sequencer_if;
  logic [5:0]  lut_addr;
  logic [13:0] lut_data;
  logic [14:0] out_sin;
  logic [14:0] out_cos;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output lut_addr,
    input  lut_data,
    output out_sin,
    output out_cos,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  lut_addr,
    output lut_data,
    input  out_sin,
    input  out_cos,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/nco_lut_sequencer.sv
// nco_lut_sequencer
// Phase accumulator and table sequencer for the NCO. Shares the single read port of a 64-entry,
// 14-bit quarter-wave sine table between a sine and a cosine lookup per sample, folds quadrants,
// applies mirror and sign, and presents a signed I/Q pair on a valid/ready handshake.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   en        : run enable; sequencer idles after the current sample when low
//   freq      : phase increment, loaded by freq_wr
//   freq_wr   : loads freq into the frequency register
//   phase_clr : pulse requesting a phase clear (applied in idle or at accept)
//   bus       : nco_lut_sequencer_if.master (table address/data, out_sin/out_cos/valid/ready)
// Build option:
//   NCO_DITHER_EN : adds a 16-bit LFSR whose low bits dither the lookup phase below the table
//                   index; the accumulator itself stays undithered.
module nco_lut_sequencer #(
  parameter int unsigned PHASE_W = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic [PHASE_W-1:0]  freq,
  input  logic                freq_wr,
  input  logic                phase_clr,
  nco_lut_sequencer_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSin, StCos, StFin, StHold} state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] freq_q;
  logic               clr_pend_q, clr_pend_d;
  logic [14:0]        sin_val_q, sin_val_d;
  logic [14:0]        out_sin_q, out_sin_d;
  logic [14:0]        out_cos_q, out_cos_d;
  logic               out_valid_q, out_valid_d;
  logic [5:0]         lut_addr;
  logic [7:0]         p_sin, p_cos;
  logic               accept;
  logic               clr_req;

  // Odd quadrants read the table mirrored: 64 - i, which is -i modulo 64 (0 stays 0).
  function automatic logic [5:0] fold_addr(input logic [7:0] p);
    return p[6] ? (6'd0 - p[5:0]) : p[5:0];
  endfunction

  // Odd quadrant with i == 0 lands on the peak, which the table does not hold.
  function automatic logic [14:0] fold_value(input logic [7:0] p, input logic [13:0] data);
    logic [14:0] mag;
    mag = (p[6] && (p[5:0] == 6'd0)) ? 15'h3FFF : {1'b0, data};
    return p[7] ? (15'd0 - mag) : mag;
  endfunction

  assign accept  = (state_q == StHold) && out_valid_q && bus.out_ready;
  assign clr_req = clr_pend_q | phase_clr;

`ifdef NCO_DITHER_EN
  localparam int unsigned DitherW = (PHASE_W - 8 > 16) ? 16 : PHASE_W - 8;

  logic [15:0]        lfsr_q;
  logic [PHASE_W-1:0] lookup_phase;

  // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, one step per accepted sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  if (DitherW > 0) begin : g_dither
    assign lookup_phase = phase_q + PHASE_W'(lfsr_q[DitherW-1:0]);
  end else begin : g_no_dither
    assign lookup_phase = phase_q;
  end

  assign p_sin = lookup_phase[PHASE_W-1 -: 8];
`else
  assign p_sin = phase_q[PHASE_W-1 -: 8];
`endif

  assign p_cos = p_sin + 8'd64;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    clr_pend_d  = clr_req;
    sin_val_d   = sin_val_q;
    out_sin_d   = out_sin_q;
    out_cos_d   = out_cos_q;
    out_valid_d = out_valid_q;
    lut_addr    = 6'd0;

    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          phase_d    = '0;
          clr_pend_d = 1'b0;
        end
        if (en) state_d = StSin;
      end
      StSin: begin
        lut_addr = fold_addr(p_sin);
        state_d  = StCos;
      end
      StCos: begin
        // Table data now reflects the sine address issued in StSin.
        lut_addr  = fold_addr(p_cos);
        sin_val_d = fold_value(p_sin, bus.lut_data);
        state_d   = StFin;
      end
      StFin: begin
        out_sin_d   = sin_val_q;
        out_cos_d   = fold_value(p_cos, bus.lut_data);
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (accept) begin
          out_valid_d = 1'b0;
          // A pending or same-cycle clear replaces the accumulate.
          if (clr_req) begin
            phase_d    = '0;
            clr_pend_d = 1'b0;
          end else begin
            phase_d = phase_q + freq_q;
          end
          state_d = en ? StSin : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      freq_q      <= '0;
      clr_pend_q  <= 1'b0;
      sin_val_q   <= '0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      clr_pend_q  <= clr_pend_d;
      sin_val_q   <= sin_val_d;
      out_sin_q   <= out_sin_d;
      out_cos_q   <= out_cos_d;
      out_valid_q <= out_valid_d;
      if (freq_wr) freq_q <= freq;
    end
  end

  assign bus.lut_addr  = lut_addr;
  assign bus.out_sin   = out_sin_q;
  assign bus.out_cos   = out_cos_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_nco_lut_sequencer.sv
module tb_nco_lut_sequencer;
  localparam int unsigned PW = 24;
  localparam real Pi = 3.14159265358979323846;

  logic          clock = 1'b0;
  logic          reset;
  logic          en;
  logic          freq_wr;
  logic          phase_clr;
  logic [PW-1:0] freq;

  nco_lut_sequencer_if bus ();

  nco_lut_sequencer #(.PHASE_W(PW)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .freq      (freq),
    .freq_wr   (freq_wr),
    .phase_clr (phase_clr),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // Quarter-wave table with a registered read port.
  logic [13:0] lut_mem [64];
  always @(posedge clock) bus.lut_data <= lut_mem[bus.lut_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_pass = 0;
  int            last_rise = 0;
  logic [29:0]   sb [$];
  logic [PW-1:0] ph;
  logic [PW-1:0] fr;
  logic [14:0]   exp_sin;
  logic [14:0]   exp_cos;

  // Reference sample: round(16384*|sin|), capped to 14 bits, with sign applied.
  function automatic logic [14:0] model_val(input logic [7:0] p);
    real s;
    real a;
    int  m;
    s = $sin(2.0 * Pi * real'(p) / 256.0);
    a = (s < 0.0) ? -s : s;
    m = $rtoi(a * 16384.0 + 0.5);
    if (m > 16383) m = 16383;
    return (s < 0.0) ? 15'(-m) : 15'(m);
  endfunction

  task automatic push_exp(input logic [PW-1:0] phase);
    logic [7:0] p;
    logic [7:0] pc;
    p  = phase[PW-1 -: 8];
    pc = p + 8'd64;
    sb.push_back({model_val(p), model_val(pc)});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic wait_valid(input string tag, input bit chk_gap);
    logic [29:0] e;
    int          n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.out_valid !== 1'b1 && n < 40);
    if (bus.out_valid !== 1'b1) begin
      check({tag, " valid timeout"}, 32'(bus.out_valid), 32'd1);
      return;
    end
    if (chk_gap) check({tag, " gap"}, 32'(cyc - last_rise), 32'd4);
    last_rise = cyc;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    exp_sin = e[29:15];
    exp_cos = e[14:0];
    check({tag, " sin"}, 32'(bus.out_sin), 32'(exp_sin));
    check({tag, " cos"}, 32'(bus.out_cos), 32'(exp_cos));
  endtask

  task automatic accept_edge(input string tag);
    @(posedge clock);
    #1;
    check({tag, " accepted"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) begin
      lut_mem[k] = 14'($rtoi(16384.0 * $sin(2.0 * Pi * real'(k) / 256.0) + 0.5));
    end
    reset = 1'b1;
    en = 1'b0;
    freq = '0;
    freq_wr = 1'b0;
    phase_clr = 1'b0;
    bus.out_ready = 1'b1;
    ph = '0;
    fr = '0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset out_sin", 32'(bus.out_sin), 32'd0);
    check("reset out_cos", 32'(bus.out_cos), 32'd0);
    check("reset lut_addr", 32'(bus.lut_addr), 32'd0);
    reset = 1'b0;
    freq = 24'h010000;
    freq_wr = 1'b1;
    @(negedge clock);
    freq_wr = 1'b0;
    fr = 24'h010000;

    // First sample latency: out_valid rises on the 4th edge after en
    en = 1'b1;
    push_exp(ph);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("first valid edge %0d", k), 32'(bus.out_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    wait_valid("sample 0", 1'b0);
    check("s0 sin literal", 32'(bus.out_sin), 32'h0000);
    check("s0 cos literal", 32'(bus.out_cos), 32'h3FFF);
    accept_edge("sample 0");
    ph += fr;

    // Full-cycle sweep with out_ready held high
    for (int n = 1; n <= 256; n++) begin
      push_exp(ph);
      wait_valid($sformatf("sample %0d", n), 1'b1);
      if (n == 1) begin
        check("s1 sin literal", 32'(bus.out_sin), 32'h0192);
        check("s1 cos literal", 32'(bus.out_cos), 32'h3FFB);
      end
      if (n == 64) begin
        check("s64 sin literal", 32'(bus.out_sin), 32'h3FFF);
        check("s64 cos literal", 32'(bus.out_cos), 32'h0000);
      end
      if (n == 160) begin
        check("s160 sin literal", 32'(bus.out_sin), 32'h52BF);
        check("s160 cos literal", 32'(bus.out_cos), 32'h52BF);
      end
      if (n == 256) begin
        check("s256 sin literal", 32'(bus.out_sin), 32'h0000);
        check("s256 cos literal", 32'(bus.out_cos), 32'h3FFF);
      end
      accept_edge($sformatf("sample %0d", n));
      ph += fr;
    end

    // Backpressure: 10 stalled cycles, then exactly one accept
    bus.out_ready = 1'b0;
    push_exp(ph);
    wait_valid("bp", 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("bp hold valid", 32'(bus.out_valid), 32'd1);
      check("bp hold sin", 32'(bus.out_sin), 32'(exp_sin));
      check("bp hold cos", 32'(bus.out_cos), 32'(exp_cos));
    end
    bus.out_ready = 1'b1;
    accept_edge("bp");
    ph += fr;
    push_exp(ph);
    wait_valid("bp next", 1'b0);
    accept_edge("bp next");
    ph += fr;

    // Phase clear requested during FIN: current sample intact, next from phase 0
    push_exp(ph);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    phase_clr = 1'b1;
    @(posedge clock);
    #1;
    phase_clr = 1'b0;
    wait_valid("clr fin", 1'b0);
    accept_edge("clr fin");
    ph = '0;
    push_exp(ph);
    wait_valid("clr fin next", 1'b1);
    check("clr fin next sin literal", 32'(bus.out_sin), 32'h0000);
    check("clr fin next cos literal", 32'(bus.out_cos), 32'h3FFF);
    accept_edge("clr fin next");
    ph += fr;

    // Phase clear on the accept edge wins over the accumulate
    push_exp(ph);
    wait_valid("clr acc", 1'b1);
    phase_clr = 1'b1;
    accept_edge("clr acc");
    phase_clr = 1'b0;
    ph = '0;
    push_exp(ph);
    wait_valid("clr acc next", 1'b1);
    check("clr acc next sin literal", 32'(bus.out_sin), 32'h0000);
    check("clr acc next cos literal", 32'(bus.out_cos), 32'h3FFF);
    accept_edge("clr acc next");
    ph += fr;

    // en dropped in COS with a frequency write mid-sample
    push_exp(ph);
    @(posedge clock);
    #1;
    en = 1'b0;
    freq = 24'h020000;
    freq_wr = 1'b1;
    @(posedge clock);
    #1;
    freq_wr = 1'b0;
    fr = 24'h020000;
    wait_valid("en drop", 1'b0);
    accept_edge("en drop");
    ph += fr;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("idle valid", 32'(bus.out_valid), 32'd0);
      check("idle lut_addr", 32'(bus.lut_addr), 32'd0);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_exp(ph);
      wait_valid($sformatf("step2 %0d", k), k > 0);
      if (k == 0) check("step2 p3 sin literal", 32'(bus.out_sin), 32'h04B5);
      if (k == 1) check("step2 p5 sin literal", 32'(bus.out_sin), 32'h07D6);
      accept_edge($sformatf("step2 %0d", k));
      ph += fr;
    end

    // Asynchronous reset in FIN discards the pair in flight
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    #2;
    reset = 1'b1;
    #1;
    check("async rst valid", 32'(bus.out_valid), 32'd0);
    check("async rst sin", 32'(bus.out_sin), 32'd0);
    check("async rst cos", 32'(bus.out_cos), 32'd0);
    check("async rst lut_addr", 32'(bus.lut_addr), 32'd0);
    ph = '0;
    fr = '0;
    @(negedge clock);
    reset = 1'b0;
    push_exp(ph);
    wait_valid("post reset", 1'b0);
    check("post reset sin literal", 32'(bus.out_sin), 32'h0000);
    accept_edge("post reset");
    ph += fr;

    // Asynchronous reset while stalled in HOLD drops out_valid at once
    bus.out_ready = 1'b0;
    push_exp(ph);
    wait_valid("hold reset", 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("hold reset valid", 32'(bus.out_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    en = 1'b0;
    bus.out_ready = 1'b1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nco_lut_sequencer.md
# nco_lut_sequencer

Sequencer and phase front-end for the NCO's 64-entry, 14-bit quarter-wave sine table. It owns the phase accumulator and time-multiplexes the table's single read port between a sine and a cosine lookup per sample. It folds quadrants, applies the mirror and sign, and presents a signed I/Q pair on a valid/ready interface to the downstream mixer. It connects directly to the table's `addr`/`data` pins; the table has a registered read with 1-cycle latency.

## Interface
- `PHASE_W`, default 24: phase accumulator and frequency word width. Must be ≥ 8.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `en` in 1: run enable; when it is low the sequencer idles after the current sample.
- `freq` in PHASE_W: phase increment per accepted sample.
- `freq_wr` in 1: loads `freq` into the internal frequency register.
- `phase_clr` in 1: one-cycle pulse requesting a phase-accumulator clear.
- `lut_addr` out 6: table address, combinational from registered state and phase.
- `lut_data` in 14: table output, valid one cycle after the address.
- `out_sin` out 15: signed sine, two's complement.
- `out_cos` out 15: signed cosine, two's complement.
- `out_valid` out 1: output pair valid.
- `out_ready` in 1: downstream accepts the pair.

## Operation
- **Lookup phase.** `p = phase[PHASE_W-1 -: 8]`. Quadrant `q = p[7:6]`, index `i = p[5:0]`. Cosine uses `p + 64`, modulo 256.
- **Magnitude.**
  - q even: address is `i`; magnitude is `lut_data`.
  - q odd: address is `64 - i`; when `i == 0`, magnitude is the constant 14'h3FFF and the LUT value is ignored. `lut_addr` is still driven as 0 in that case.
- **Sign.** q = 0 or 1 gives `+mag`; q = 2 or 3 gives `-mag`, sign-extended to 15 bits. `-0` is 0.
- **FSM states:** IDLE, SIN, COS, FIN, HOLD.
  - IDLE: `lut_addr` = 0. Go to SIN when `en` = 1.
  - SIN: drive the sine address. Go to COS.
  - COS: drive the cosine address and capture the sine magnitude from `lut_data`. Go to FIN.
  - FIN: capture the cosine magnitude. Register `out_sin` and `out_cos`, set `out_valid` = 1. Go to HOLD.
  - HOLD: hold the outputs stable while `out_ready` = 0.
    - On `out_valid && out_ready`: `phase <= phase + freq` (wraps modulo 2^PHASE_W) and `out_valid <= 0`.
    - Next state is SIN if `en` = 1, otherwise IDLE.
- **Frequency register.** Loaded on any cycle with `freq_wr`. The new value is used at the next accumulate; a sample in flight is unaffected. The reset value is 0.
- **Phase clear.**
  - A `phase_clr` pulse sets a pending flag.
  - The flag is applied in IDLE, or at accept, in place of the accumulate: `phase <= 0`, then the flag clears.
  - `phase_clr` together with an accept in the same cycle: the clear wins.
  - A sample already in flight is never torn.
- **`en` dropped mid-sample** (in SIN, COS or FIN): the sample completes and is delivered; the FSM then goes to IDLE after accept.
- **Reset values:** state IDLE, phase 0, freq register 0, pending flag 0, `out_sin` = `out_cos` = 0, `out_valid` = 0.
- **Reset mid-operation:** the block returns to these values immediately; the pair in flight is discarded.

## Timing
- From the first edge with `en` = 1 in IDLE: SIN, COS and FIN follow on consecutive edges. `out_valid` rises at the 4th edge.
- With `out_ready` held at 1: one sample every 4 cycles (SIN → COS → FIN → HOLD).
- `lut_addr` changes only on state or phase edges. The LUT's registered output is sampled exactly one cycle after its address.
- `out_sin`/`out_cos` are stable from the `out_valid` rise through the accept edge.

## Configuration
- **`NCO_DITHER_EN` defined:**
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances once per accept.
  - Lookup phase is `phase + dither`. `dither` is the LFSR's low `min(16, PHASE_W-8)` bits, zero-extended; this dithers below the table index bits.
  - The phase accumulator itself is undithered.
- **Undefined:** no LFSR; the lookup phase is plain truncation of `phase`. All test-plan values below assume it is undefined.

## Test plan
- **Reset and first sample.** Reset, then `PHASE_W` = 24, `freq_wr` with 24'h010000, `en` = 1, `out_ready` = 1. Sample 0 must be `out_sin` = 0, `out_cos` = 15'h3FFF; sample 1 must be `out_sin` = 15'h0192, `out_cos` = 15'h3FFB. Samples must be spaced 4 cycles apart, with `out_valid` first rising on the 4th edge after `en`.
- **Quadrant sweep.** Same `freq`.
  - Sample 64: `out_sin` = 15'h3FFF, `out_cos` = 0.
  - Sample 160: `out_sin` = 15'h52BF (−0x2D41), `out_cos` = 15'h52BF.
  - Sample 256: wraps back to `out_sin` = 0, `out_cos` = 15'h3FFF.
- **Backpressure.** Hold `out_ready` = 0 for 10 cycles in HOLD: outputs are stable and phase is unchanged. Release: exactly one accept occurs, and the phase advances once.
- **Phase clear.** `phase_clr` at sample 5's FIN cycle: sample 5 is delivered unchanged, and the next sample has `out_sin` = 0, `out_cos` = 15'h3FFF. Repeat with `phase_clr` coinciding with the accept edge: the clear wins.
- **Enable and frequency change.** Drop `en` during COS: the pair is delivered, then the FSM idles with `lut_addr` = 0. A `freq_wr` to 24'h020000 mid-sample takes effect only at the next accumulate; consecutive sine outputs then step by 2 table entries.
- **Asynchronous reset.** Assert `reset` asynchronously in FIN: `out_valid` drops immediately and the phase reads 0; the first sample after release is `out_sin` = 0.
